// File: rtl/aux_cond_pkg.sv
// Shared types and constants for the AUX pulse conditioner.
//   aux_state_e        : measurement FSM states (idle, high phase, low phase)
//   DEFAULT_WIDTH_BITS : default width of the measurement counters and outputs
package aux_cond_pkg;

    localparam int unsigned DEFAULT_WIDTH_BITS = 26;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } aux_state_e;

endpackage

// File: rtl/aux_pulse_conditioner_if.sv
// Signal bundle between the AUX pulse conditioner and its neighbours.
//   AUX_INPUT  : raw asynchronous input into the conditioner
//   AUX_CLEAN  : synchronised (optionally filtered) level
//   RISE_PULSE : 1-cycle strobe when AUX_CLEAN goes 0->1
//   FALL_PULSE : 1-cycle strobe when AUX_CLEAN goes 1->0
//   HIGH_WIDTH : high time of the last measured cycle
//   PERIOD     : rise-to-rise time of the last measured cycle
//   MEAS_VALID : 1-cycle strobe, measurement outputs updated
//   MEAS_OVF   : last report ended by counter saturation
// Modports: master = conditioner side, slave = source/consumer side.
interface aux_pulse_conditioner_if
    import aux_cond_pkg::*;
#(
    parameter int unsigned WIDTH_BITS = DEFAULT_WIDTH_BITS
);
    logic                  AUX_INPUT;
    logic                  AUX_CLEAN;
    logic                  RISE_PULSE;
    logic                  FALL_PULSE;
    logic [WIDTH_BITS-1:0] HIGH_WIDTH;
    logic [WIDTH_BITS-1:0] PERIOD;
    logic                  MEAS_VALID;
    logic                  MEAS_OVF;

    modport master (
        input  AUX_INPUT,
        output AUX_CLEAN, RISE_PULSE, FALL_PULSE, HIGH_WIDTH, PERIOD, MEAS_VALID, MEAS_OVF
    );

    modport slave (
        output AUX_INPUT,
        input  AUX_CLEAN, RISE_PULSE, FALL_PULSE, HIGH_WIDTH, PERIOD, MEAS_VALID, MEAS_OVF
    );
endinterface

// File: rtl/aux_glitch_filter.sv
// Synchroniser, glitch filter and edge strobes for AUX_INPUT.
//   CLOCK_50   in  : clock, all logic on posedge
//   RESET      in  : synchronous active-high reset
//   AUX_INPUT  in  : raw asynchronous input
//   AUX_CLEAN  out : clean level
//   RISE_PULSE out : high in the first cycle AUX_CLEAN shows 1
//   FALL_PULSE out : high in the first cycle AUX_CLEAN shows 0
// Macro AUX_GLITCH_FILTER_EN: when defined, AUX_CLEAN only changes after FILT_LEN
// consecutive disagreeing samples; otherwise it is the synchroniser output registered once.
module aux_glitch_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 16
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic AUX_INPUT,
    output logic AUX_CLEAN,
    output logic RISE_PULSE,
    output logic FALL_PULSE
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   clean_q, clean_d;
    logic                   rise_q, fall_q;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], AUX_INPUT};
        end
    end

`ifdef AUX_GLITCH_FILTER_EN
    localparam int unsigned CntW = $clog2(FILT_LEN + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count disagreeing samples; the FILT_LEN-th one flips the level and clears the count.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (sync_out != clean_q) begin
            if (cnt_q == CntW'(FILT_LEN - 1)) begin
                clean_d = ~clean_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        clean_d = sync_out;
    end
`endif

    // Strobes are registered alongside the level so they line up with the new value.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            clean_q <= clean_d;
            rise_q  <= clean_d & ~clean_q;
            fall_q  <= ~clean_d & clean_q;
        end
    end

    assign AUX_CLEAN  = clean_q;
    assign RISE_PULSE = rise_q;
    assign FALL_PULSE = fall_q;

endmodule

// File: rtl/aux_pulse_conditioner.sv
// Front-end conditioner for AUX_INPUT: clean level, edge strobes and per-cycle
// high-width / period measurement.
//   CLOCK_50 in : clock, all logic on posedge
//   RESET    in : synchronous active-high reset
//   aux      io : aux_pulse_conditioner_if.master (AUX_INPUT in; level, strobes,
//                 HIGH_WIDTH, PERIOD, MEAS_VALID, MEAS_OVF out)
// Macro AUX_GLITCH_FILTER_EN enables the glitch filter in aux_glitch_filter.
module aux_pulse_conditioner
    import aux_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 16,
    parameter int unsigned WIDTH_BITS  = DEFAULT_WIDTH_BITS
) (
    input logic                     CLOCK_50,
    input logic                     RESET,
    aux_pulse_conditioner_if.master aux
);

    localparam logic [WIDTH_BITS-1:0] CntMax = '1;
    localparam logic [WIDTH_BITS-1:0] CntOne = WIDTH_BITS'(1);

    logic clean, rise, fall;

    aux_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filter (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .AUX_INPUT  (aux.AUX_INPUT),
        .AUX_CLEAN  (clean),
        .RISE_PULSE (rise),
        .FALL_PULSE (fall)
    );

    aux_state_e            state_q, state_d;
    logic [WIDTH_BITS-1:0] high_cnt_q, high_cnt_d;
    logic [WIDTH_BITS-1:0] per_cnt_q, per_cnt_d;
    logic [WIDTH_BITS-1:0] high_width_q, high_width_d;
    logic [WIDTH_BITS-1:0] period_q, period_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        state_d      = state_q;
        high_cnt_d   = high_cnt_q;
        per_cnt_d    = per_cnt_q;
        high_width_d = high_width_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        ovf_d        = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    high_cnt_d = CntOne;
                    per_cnt_d  = CntOne;
                    state_d    = StHigh;
                end
            end
            StHigh, StLow: begin
                if (per_cnt_q == CntMax) begin
                    // Saturated: report what we have and wait for a fresh rise.
                    high_width_d = high_cnt_q;
                    period_d     = per_cnt_q;
                    ovf_d        = 1'b1;
                    valid_d      = 1'b1;
                    state_d      = StIdle;
                end else if (state_q == StHigh) begin
                    per_cnt_d = per_cnt_q + 1'b1;
                    if (fall) begin
                        state_d = StLow;
                    end else begin
                        high_cnt_d = high_cnt_q + 1'b1;
                    end
                end else if (rise) begin
                    high_width_d = high_cnt_q;
                    period_d     = per_cnt_q;
                    ovf_d        = 1'b0;
                    valid_d      = 1'b1;
                    high_cnt_d   = CntOne;
                    per_cnt_d    = CntOne;
                    state_d      = StHigh;
                end else begin
                    per_cnt_d = per_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q      <= StIdle;
            high_cnt_q   <= '0;
            per_cnt_q    <= '0;
            high_width_q <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            high_cnt_q   <= high_cnt_d;
            per_cnt_q    <= per_cnt_d;
            high_width_q <= high_width_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign aux.AUX_CLEAN  = clean;
    assign aux.RISE_PULSE = rise;
    assign aux.FALL_PULSE = fall;
    assign aux.HIGH_WIDTH = high_width_q;
    assign aux.PERIOD     = period_q;
    assign aux.MEAS_VALID = valid_q;
    assign aux.MEAS_OVF   = ovf_q;

endmodule

// File: tb/tb_aux_pulse_conditioner.sv
// Bench for aux_pulse_conditioner: directed stimulus, expected reports queued at
// stimulus time and popped by a monitor whenever MEAS_VALID is seen.
module tb_aux_pulse_conditioner;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FILT = 4;
    localparam int unsigned W    = 8;
`ifdef AUX_GLITCH_FILTER_EN
    localparam int LAT = SYNC + FILT;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    aux_pulse_conditioner_if #(.WIDTH_BITS(W)) aux ();

    aux_pulse_conditioner #(
        .SYNC_STAGES (SYNC),
        .FILT_LEN    (FILT),
        .WIDTH_BITS  (W)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .aux      (aux)
    );

    typedef struct packed {
        logic [W-1:0] hw;
        logic [W-1:0] per;
        logic         ovf;
    } meas_t;

    meas_t exp_q[$];
    meas_t mon_e;
    int    total = 0;
    int    bad   = 0;
    logic  prev_rise = 1'b0;

    function automatic void check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    function automatic void push_exp(input int h, input int p, input logic o);
        meas_t m;
        m.hw  = W'(h);
        m.per = W'(p);
        m.ovf = o;
        exp_q.push_back(m);
    endfunction

    function automatic longint all_outs();
        return longint'({aux.AUX_CLEAN, aux.RISE_PULSE, aux.FALL_PULSE, aux.MEAS_VALID,
                         aux.MEAS_OVF, aux.HIGH_WIDTH, aux.PERIOD});
    endfunction

    // Monitor: strobe exclusivity every cycle, report contents on MEAS_VALID.
    always @(negedge CLOCK_50) begin
        if (!RESET) begin
            check("strobe_exclusive", longint'(aux.RISE_PULSE & aux.FALL_PULSE), 0);
            if (aux.MEAS_VALID) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got MEAS_VALID hw=%0d per=%0d, want none",
                             aux.HIGH_WIDTH, aux.PERIOD);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("high_width", longint'(aux.HIGH_WIDTH), longint'(mon_e.hw));
                    check("period", longint'(aux.PERIOD), longint'(mon_e.per));
                    check("meas_ovf", longint'(aux.MEAS_OVF), longint'(mon_e.ovf));
                    if (!mon_e.ovf) begin
                        check("valid_after_rise", longint'(prev_rise), 1);
                    end
                end
            end
        end
        prev_rise = aux.RISE_PULSE;
    end

    // Hold the input at lvl for n sampling edges; called just after a posedge.
    task automatic drive(input logic lvl, input int n);
        aux.AUX_INPUT = lvl;
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        drive(1'b0, 2);
        RESET = 1'b0;
        drive(1'b0, 2);
    endtask

    task automatic drain(input string name);
        drive(aux.AUX_INPUT, LAT + 6);
        check(name, longint'(exp_q.size()), 0);
    endtask

    task automatic pulse(input int w, input int win, output int rises, output int falls,
                         output int first_rise, output int first_fall, output int hi);
        rises = 0; falls = 0; first_rise = -1; first_fall = -1; hi = 0;
        aux.AUX_INPUT = 1'b1;
        for (int c = 1; c <= win; c++) begin
            @(posedge CLOCK_50);
            #1;
            if (c == w) aux.AUX_INPUT = 1'b0;
            if (aux.RISE_PULSE) begin
                rises++;
                if (first_rise < 0) first_rise = c;
            end
            if (aux.FALL_PULSE) begin
                falls++;
                if (first_fall < 0) first_fall = c;
            end
            if (aux.AUX_CLEAN) hi++;
        end
    endtask

    // Square wave of n periods; the first rise of the burst is not reported.
    task automatic wave(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            if (p > 0) push_exp(h, h + l, 1'b0);
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    // Pulse table: width, expected rises, first rise cycle, first fall cycle, high cycles.
`ifdef AUX_GLITCH_FILTER_EN
    int pw[3]    = '{3, 4, 6};
    int pn[3]    = '{0, 1, 1};
    int prise[3] = '{-1, 6, 6};
    int pfall[3] = '{-1, 10, 12};
    int phi[3]   = '{0, 4, 6};
`else
    int pw[3]    = '{1, 2, 3};
    int pn[3]    = '{1, 1, 1};
    int prise[3] = '{3, 3, 3};
    int pfall[3] = '{4, 5, 6};
    int phi[3]   = '{1, 2, 3};
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish by 1ms, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rs, fs, fr, ff, hc;

        // Reset held with a toggling input.
        aux.AUX_INPUT = 1'b0;
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            aux.AUX_INPUT = ~aux.AUX_INPUT;
            @(posedge CLOCK_50);
            #1;
            check("reset_outputs", all_outs(), 0);
        end
        RESET = 1'b0;
        drive(1'b0, 6);
        check("post_reset_outputs", all_outs(), 0);

        // Short and long pulses through the front end.
        for (int i = 0; i < 3; i++) begin
            do_reset();
            pulse(pw[i], pw[i] + LAT + 8, rs, fs, fr, ff, hc);
            check("pulse_rises", rs, pn[i]);
            check("pulse_falls", fs, pn[i]);
            check("pulse_rise_cycle", fr, prise[i]);
            check("pulse_fall_cycle", ff, pfall[i]);
            check("pulse_high_cycles", hc, phi[i]);
        end
        do_reset();
        drain("pulse_queue_empty");

        // Periodic wave, back-to-back reports.
        do_reset();
        wave(50, 30, 4);
        push_exp(50, 80, 1'b0);
        drive(1'b1, 5);
        drain("wave_queue_empty");

        // Saturation while stuck high, then a fresh measurement.
        do_reset();
        push_exp(255, 255, 1'b1);
        drive(1'b1, 400);
        check("sat_ovf_held", longint'(aux.MEAS_OVF), 1);
        check("sat_width_held", longint'(aux.HIGH_WIDTH), 255);
        drive(1'b0, 30);
        wave(20, 20, 1);
        push_exp(20, 40, 1'b0);
        drive(1'b1, 5);
        drain("sat_queue_empty");
        check("sat_ovf_cleared", longint'(aux.MEAS_OVF), 0);

        // Reset in the middle of a high phase.
        do_reset();
        wave(20, 20, 1);
        push_exp(20, 40, 1'b0);
        drive(1'b1, 12);
        RESET = 1'b1;
        drive(1'b1, 2);
        check("midhigh_reset_outputs", all_outs(), 0);
        check("midhigh_queue_empty", longint'(exp_q.size()), 0);
        RESET = 1'b0;
        drive(1'b1, 25);
        drive(1'b0, 20);
        push_exp(25, 45, 1'b0);
        drive(1'b1, 5);
        drain("midhigh_final_queue_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
